// File: rtl/pmci_vdm_pkt_buf_if.sv
// pmci_vdm_pkt_buf_if: CSR access port and packet stream of the VDM packet buffer
interface pmci_vdm_pkt_buf_if #(parameter int DATA_W = 64);
  logic              csr_wr;
  logic              csr_rd;
  logic [3:0]        csr_addr;
  logic [DATA_W-1:0] csr_wdata;
  logic [DATA_W-1:0] csr_rdata;
  logic              csr_rvalid;
  logic              m_tvalid;
  logic [DATA_W-1:0] m_tdata;
  logic              m_tlast;
  logic              m_tready;
  modport master (
    output csr_wr, csr_rd, csr_addr, csr_wdata, m_tready,
    input  csr_rdata, csr_rvalid, m_tvalid, m_tdata, m_tlast
  );
  modport slave (
    input  csr_wr, csr_rd, csr_addr, csr_wdata, m_tready,
    output csr_rdata, csr_rvalid, m_tvalid, m_tdata, m_tlast
  );
endinterface

// File: rtl/pmci_vdm_pkt_buf.sv
// pmci_vdm_pkt_buf: CSR-filled packet FIFO that only streams out fully committed packets
module pmci_vdm_pkt_buf #(
  parameter int DATA_W    = 64,
  parameter int DEPTH     = 64,
  parameter int MAX_PKT_W = 32
) (
  input logic clk,
  input logic rst,
  pmci_vdm_pkt_buf_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE = 2'd0, FILL = 2'd1} state_t;
  state_t state_q, state_d;
  logic [AW:0] wr_q, wr_d, rd_q, rd_d, cm_q, cm_d, free;
  logic [15:0] rem_q, rem_d, pkt_q, pkt_d, err_q, err_d, len;
  logic len_err_q, len_err_d, ovf_err_q, ovf_err_d, rvalid_q;
  logic [DATA_W-1:0] rdata_q, fcr_val;
  logic [DATA_W:0] mem_q [DEPTH];
  logic fcr_wr, pdr_wr, start, push, pop, pkt_inc;
  logic [1:0] err_inc;
  logic [16:0] err_sum;
  assign fcr_wr = bus.csr_wr && bus.csr_addr == 4'h0;
  assign pdr_wr = bus.csr_wr && bus.csr_addr == 4'h8;
  assign start = fcr_wr && bus.csr_wdata[31];
  assign len = bus.csr_wdata[15:0];
  // Free space ignores the open packet: a restart rewinds it before the check
  assign free = (AW+1)'(DEPTH) - (cm_q - rd_q);
  assign bus.m_tvalid = rd_q != cm_q;
  assign {bus.m_tlast, bus.m_tdata} = mem_q[rd_q[AW-1:0]];
  assign bus.csr_rdata = rdata_q;
  assign bus.csr_rvalid = rvalid_q;
  assign pop = bus.m_tvalid && bus.m_tready;
  assign err_sum = {1'b0, err_q} + {15'b0, err_inc};
  assign err_d = err_sum[16] ? 16'hFFFF : err_sum[15:0];
  assign pkt_d = (pkt_inc && pkt_q != 16'hFFFF) ? pkt_q + 16'd1 : pkt_q;
  always_comb begin
    fcr_val = '0;
    fcr_val[47:32] = err_q;
    fcr_val[31:16] = pkt_q;
    fcr_val[9:8] = state_q;
    fcr_val[1:0] = {ovf_err_q, len_err_q};
  end
  always_comb begin
    state_d = state_q;
    wr_d = wr_q;
    rd_d = pop ? rd_q + 1'b1 : rd_q;
    cm_d = cm_q;
    rem_d = rem_q;
    len_err_d = len_err_q;
    ovf_err_d = ovf_err_q;
    err_inc = 2'd0;
    pkt_inc = 1'b0;
    push = 1'b0;
    if (fcr_wr && bus.csr_wdata[63]) begin
      len_err_d = 1'b0;
      ovf_err_d = 1'b0;
    end
    if (start) begin
      if (state_q == FILL) begin
        wr_d = cm_q;
        len_err_d = 1'b1;
        err_inc = 2'd1;
      end
      state_d = IDLE;
      if (len == 16'd0 || 32'(len) > MAX_PKT_W) begin
        len_err_d = 1'b1;
        err_inc = err_inc + 2'd1;
      end else if (32'(free) < 32'(len)) begin
        ovf_err_d = 1'b1;
        err_inc = err_inc + 2'd1;
      end else begin
        state_d = FILL;
        rem_d = len;
      end
    end else if (pdr_wr) begin
      if (state_q == FILL) begin
        push = 1'b1;
        wr_d = wr_q + 1'b1;
        rem_d = rem_q - 16'd1;
        if (rem_q == 16'd1) begin
          cm_d = wr_q + 1'b1;
          pkt_inc = 1'b1;
          state_d = IDLE;
        end
      end else begin
        len_err_d = 1'b1;
        err_inc = 2'd1;
      end
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      wr_q <= '0;
      rd_q <= '0;
      cm_q <= '0;
      rem_q <= '0;
      pkt_q <= '0;
      err_q <= '0;
      len_err_q <= 1'b0;
      ovf_err_q <= 1'b0;
      rvalid_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      cm_q <= cm_d;
      rem_q <= rem_d;
      pkt_q <= pkt_d;
      err_q <= err_d;
      len_err_q <= len_err_d;
      ovf_err_q <= ovf_err_d;
      rvalid_q <= bus.csr_rd;
      if (bus.csr_rd) rdata_q <= bus.csr_addr == 4'h0 ? fcr_val : '0;
    end
  always_ff @(posedge clk)
    if (push) mem_q[wr_q[AW-1:0]] <= {rem_q == 16'd1, bus.csr_wdata};
endmodule

// File: tb/tb_pmci_vdm_pkt_buf.sv
// tb_pmci_vdm_pkt_buf: randomized and directed checks against a queue-based packet model
module tb_pmci_vdm_pkt_buf;
  localparam int DW = 64, DEPTH = 64, MAXW = 32;
  localparam logic [63:0] START = 64'h8000_0000;
  typedef struct packed {logic last; logic [63:0] data;} word_t;
  logic clk = 0, rst = 1, ready = 0;
  int checks = 0, errors = 0, words = 0, lasts = 0;
  word_t outq[$], openq[$];
  bit filling, lerr, oerr, exp_rv;
  int pktc, errc, rem;
  logic [63:0] exp_rdata, v;
  pmci_vdm_pkt_buf_if #(.DATA_W(DW)) bus();
  pmci_vdm_pkt_buf #(.DATA_W(DW), .DEPTH(DEPTH), .MAX_PKT_W(MAXW)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int sat(input int x);
    return x > 65535 ? 65535 : x;
  endfunction

  function automatic logic [63:0] fcr_model();
    return {16'b0, 16'(sat(errc)), 16'(sat(pktc)), 6'b0, 2'(filling), 6'b0, oerr, lerr};
  endfunction

  task automatic model_reset();
    outq.delete(); openq.delete();
    filling = 0; lerr = 0; oerr = 0; exp_rv = 0; pktc = 0; errc = 0; rem = 0;
  endtask

  task automatic model_step(input logic wr, rd, input logic [3:0] addr, input logic [63:0] wd);
    bit pop;
    int occ, len;
    pop = outq.size() != 0 && ready;
    occ = outq.size();
    exp_rv = rd;
    if (rd) exp_rdata = addr == 4'h0 ? fcr_model() : 64'h0;
    if (wr && addr == 4'h0 && wd[63]) begin lerr = 0; oerr = 0; end
    if (wr && addr == 4'h0 && wd[31]) begin
      if (filling) begin openq.delete(); lerr = 1; errc++; end
      filling = 0;
      len = int'(wd[15:0]);
      if (len == 0 || len > MAXW) begin lerr = 1; errc++; end
      else if (DEPTH - occ < len) begin oerr = 1; errc++; end
      else begin filling = 1; rem = len; end
    end else if (wr && addr == 4'h8) begin
      if (filling) begin
        rem--;
        openq.push_back({rem == 0, wd});
        if (rem == 0) begin
          foreach (openq[i]) outq.push_back(openq[i]);
          openq.delete();
          pktc++;
          filling = 0;
        end
      end else begin lerr = 1; errc++; end
    end
    if (pop) void'(outq.pop_front());
  endtask

  task automatic cycle(input logic wr, rd, input logic [3:0] addr, input logic [63:0] wd);
    bus.csr_wr = wr; bus.csr_rd = rd; bus.csr_addr = addr; bus.csr_wdata = wd; bus.m_tready = ready;
    check("tvalid", bus.m_tvalid, 64'(outq.size() != 0));
    if (outq.size() != 0) begin
      check("tdata", bus.m_tdata, outq[0].data);
      check("tlast", bus.m_tlast, 64'(outq[0].last));
    end
    check("rvalid", bus.csr_rvalid, 64'(exp_rv));
    if (exp_rv) check("rdata", bus.csr_rdata, exp_rdata);
    if (bus.m_tvalid && ready) begin words++; lasts += int'(bus.m_tlast); end
    model_step(wr, rd, addr, wd);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 4'h0, 64'h0);
  endtask
  task automatic fcr(input logic [63:0] wd); cycle(1, 0, 4'h0, wd); endtask
  task automatic pdr(input logic [63:0] wd); cycle(1, 0, 4'h8, wd); endtask
  task automatic rd_fcr(output logic [63:0] val);
    cycle(0, 1, 4'h0, 64'h0);
    val = bus.csr_rdata;
  endtask

  task automatic rst_pulse();
    bus.csr_wr = 0; bus.csr_rd = 0;
    #2 rst = 1;
    #1;
    check("rst_tvalid", bus.m_tvalid, 0);
    check("rst_rvalid", bus.csr_rvalid, 0);
    check("rst_rdata", bus.csr_rdata, 0);
    model_reset();
    @(negedge clk);
    rst = 0;
  endtask

  task automatic drain();
    for (int g = 0; g < 300 && outq.size() != 0; g++) idle(1);
    check("drain_empty", 64'(outq.size()), 0);
  endtask

  initial begin
    int w0, l0, sum;
    bus.csr_wr = 0; bus.csr_rd = 0; bus.csr_addr = 0; bus.csr_wdata = 0; bus.m_tready = 0;
    model_reset();
    rst_pulse();
    rd_fcr(v);
    check("reset_fcr", v, 0);
    // basic 3-word packet
    ready = 1; w0 = words; l0 = lasts;
    fcr(START | 3); pdr(64'hA); pdr(64'hB); pdr(64'hC); idle(4);
    rd_fcr(v);
    check("p1_pkt_cnt", v[31:16], 1);
    check("p1_status", v[1:0], 0);
    check("p1_words", 64'(words - w0), 3);
    check("p1_lasts", 64'(lasts - l0), 1);
    // premature restart discards the open packet
    rst_pulse(); w0 = words;
    fcr(START | 4); pdr(64'h11); pdr(64'h22); fcr(START | 2); pdr(64'h33); pdr(64'h44); idle(4);
    rd_fcr(v);
    check("p2_len_err", v[0], 1);
    check("p2_err_cnt", v[47:32], 1);
    check("p2_pkt_cnt", v[31:16], 1);
    check("p2_words", 64'(words - w0), 2);
    // full FIFO then overflow
    rst_pulse(); ready = 0;
    for (int p = 0; p < 2; p++) begin
      fcr(START | MAXW);
      for (int k = 0; k < MAXW; k++) pdr({$urandom, $urandom});
    end
    fcr(START | 1);
    rd_fcr(v);
    check("p3_ovf", v[1], 1);
    check("p3_state_idle", v[9:8], 0);
    ready = 1; w0 = words; l0 = lasts;
    drain();
    check("p3_words", 64'(words - w0), 64);
    check("p3_lasts", 64'(lasts - l0), 2);
    // length errors, stray PDR write, clear with simultaneous read
    rst_pulse();
    fcr(START | 0); fcr(START | (MAXW + 1)); pdr(64'h5);
    rd_fcr(v);
    check("p4_err_cnt", v[47:32], 3);
    check("p4_len_err", v[0], 1);
    cycle(1, 1, 4'h0, 64'h8000_0000_0000_0000);
    check("p4_rdwr_pre", v[0], bus.csr_rdata[0]);
    rd_fcr(v);
    check("p4_cleared", v[0], 0);
    check("p4_err_keep", v[47:32], 3);
    check("p4_pdr_read", 64'(outq.size()), 0);
    cycle(0, 1, 4'h8, 64'h0);
    check("p4_pdr_rd0", bus.csr_rdata, 0);
    // reset mid-fill
    w0 = words; l0 = lasts;
    fcr(START | 5); pdr(64'h1); pdr(64'h2);
    rst_pulse();
    fcr(START | 1); pdr(64'h77); idle(3);
    check("p5_words", 64'(words - w0), 1);
    check("p5_lasts", 64'(lasts - l0), 1);
    // random packets across pointer wrap
    rst_pulse(); w0 = words; sum = 0;
    for (int p = 0; p < 200; p++) begin
      int len, g;
      len = $urandom_range(1, MAXW);
      sum += len;
      for (g = 0; g < 200 && DEPTH - outq.size() < len; g++) begin ready = 1; idle(1); end
      if (g == 200) check("wait_free", 0, 1);
      ready = 1'($urandom);
      fcr(START | 64'(len));
      for (int k = 0; k < len; k++) begin
        ready = 1'($urandom);
        if ($urandom_range(0, 3) == 0) idle(1);
        pdr({$urandom, $urandom});
      end
    end
    ready = 1;
    drain();
    rd_fcr(v);
    check("rnd_pkt_cnt", v[31:16], 200);
    check("rnd_status", v[1:0], 0);
    check("rnd_words", 64'(words - w0), 64'(sum));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
